// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the memory access stage.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'd0,
    MEM_HALF    = 2'd1,
    MEM_WORD    = 2'd2,
    MEM_ILLEGAL = 2'd3
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Illegal size is handled as a word everywhere below.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lo[0];
      default:  return |lo;
    endcase
  endfunction

  function automatic logic [3:0] store_byte_en(input mem_size_e size, input logic [1:0] lo);
    case (size)
      MEM_BYTE: return 4'b0001 << lo;
      MEM_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input mem_size_e size, input logic [31:0] data);
    case (size)
      MEM_BYTE: return {4{data[7:0]}};
      MEM_HALF: return {2{data[15:0]}};
      default:  return data;
    endcase
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Selects the addressed byte/half lane of a read word and sign/zero extends it.
module load_data_aligner
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      MEM_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: req/ack data memory access, store lane steering,
// load alignment and the MEM/WB pipeline register.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exValid,
  input  logic [31:0] exAluOutput,
  input  logic [31:0] exStoreData,
  input  logic        exMemRead,
  input  logic        exMemWrite,
  input  logic [1:0]  exMemSize,
  input  logic        exMemUnsigned,
  input  logic        exMemToReg,
  input  logic        exRegWrite,
  input  logic [4:0]  exWriteReg,
  output logic        memStall,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [3:0]  dmemByteEn,
  input  logic [31:0] dmemRdata,
  input  logic        dmemAck,
  output logic        wbValid,
  output logic [31:0] wbMemoryData,
  output logic [31:0] wbAluOutput,
  output logic        wbMemOutOrAluOut,
  output logic        wbRegWrite,
  output logic [4:0]  wbWriteReg,
  output logic        misalignedFault
);

  state_e      state_q, state_d;
  logic [31:0] req_alu_q, req_alu_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_be_q, req_be_d;
  logic        req_we_q, req_we_d;
  mem_size_e   req_size_q, req_size_d;
  logic        req_uns_q, req_uns_d;
  logic        req_m2r_q, req_m2r_d;
  logic        req_rw_q, req_rw_d;
  logic [4:0]  req_wreg_q, req_wreg_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_mem_data_q, wb_mem_data_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic        wb_m2r_q, wb_m2r_d;
  logic        wb_rw_q, wb_rw_d;
  logic [4:0]  wb_wreg_q, wb_wreg_d;
  logic        fault_q, fault_d;

  mem_size_e   ex_size;
  logic        ex_is_mem;
  logic        ex_mis;
  logic [31:0] load_data;

  assign ex_size   = mem_size_e'(exMemSize);
  assign ex_is_mem = exMemRead | exMemWrite;
  assign ex_mis    = ex_is_mem & is_misaligned(ex_size, exAluOutput[1:0]);

  load_data_aligner u_aligner (
    .rdata       (dmemRdata),
    .addr_lo     (req_alu_q[1:0]),
    .size        (req_size_q),
    .is_unsigned (req_uns_q),
    .data        (load_data)
  );

  always_comb begin
    state_d       = state_q;
    req_alu_d     = req_alu_q;
    req_wdata_d   = req_wdata_q;
    req_be_d      = req_be_q;
    req_we_d      = req_we_q;
    req_size_d    = req_size_q;
    req_uns_d     = req_uns_q;
    req_m2r_d     = req_m2r_q;
    req_rw_d      = req_rw_q;
    req_wreg_d    = req_wreg_q;
    wb_valid_d    = 1'b0;
    wb_mem_data_d = wb_mem_data_q;
    wb_alu_d      = wb_alu_q;
    wb_m2r_d      = wb_m2r_q;
    wb_rw_d       = 1'b0;
    wb_wreg_d     = wb_wreg_q;
    fault_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (exValid) begin
          if (!ex_is_mem) begin
            wb_valid_d = 1'b1;
            wb_alu_d   = exAluOutput;
            wb_m2r_d   = exMemToReg;
            wb_rw_d    = exRegWrite;
            wb_wreg_d  = exWriteReg;
          end else if (ex_mis) begin
            fault_d = 1'b1;
          end else begin
            state_d     = BUSY;
            req_alu_d   = exAluOutput;
            req_we_d    = exMemWrite;
            req_wdata_d = exMemWrite ? store_wdata(ex_size, exStoreData) : '0;
            req_be_d    = exMemWrite ? store_byte_en(ex_size, exAluOutput[1:0]) : '0;
            req_size_d  = ex_size;
            req_uns_d   = exMemUnsigned;
            req_m2r_d   = exMemToReg;
            req_rw_d    = exRegWrite & ~exMemWrite;
            req_wreg_d  = exWriteReg;
          end
        end
      end
      BUSY: begin
        if (dmemAck) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_alu_d   = req_alu_q;
          wb_m2r_d   = req_m2r_q;
          wb_rw_d    = req_rw_q;
          wb_wreg_d  = req_wreg_q;
          if (!req_we_q) wb_mem_data_d = load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_alu_q     <= '0;
      req_wdata_q   <= '0;
      req_be_q      <= '0;
      req_we_q      <= 1'b0;
      req_size_q    <= MEM_BYTE;
      req_uns_q     <= 1'b0;
      req_m2r_q     <= 1'b0;
      req_rw_q      <= 1'b0;
      req_wreg_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_mem_data_q <= '0;
      wb_alu_q      <= '0;
      wb_m2r_q      <= 1'b0;
      wb_rw_q       <= 1'b0;
      wb_wreg_q     <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_alu_q     <= req_alu_d;
      req_wdata_q   <= req_wdata_d;
      req_be_q      <= req_be_d;
      req_we_q      <= req_we_d;
      req_size_q    <= req_size_d;
      req_uns_q     <= req_uns_d;
      req_m2r_q     <= req_m2r_d;
      req_rw_q      <= req_rw_d;
      req_wreg_q    <= req_wreg_d;
      wb_valid_q    <= wb_valid_d;
      wb_mem_data_q <= wb_mem_data_d;
      wb_alu_q      <= wb_alu_d;
      wb_m2r_q      <= wb_m2r_d;
      wb_rw_q       <= wb_rw_d;
      wb_wreg_q     <= wb_wreg_d;
      fault_q       <= fault_d;
    end
  end

  // Stall and request depend on state alone, so upstream sees no path from ex* or ack.
  assign memStall         = (state_q == BUSY);
  assign dmemReq          = (state_q == BUSY);
  assign dmemWe           = (state_q == BUSY) & req_we_q;
  assign dmemAddr         = {req_alu_q[31:2], 2'b00};
  assign dmemWdata        = req_wdata_q;
  assign dmemByteEn       = req_be_q;
  assign wbValid          = wb_valid_q;
  assign wbMemoryData     = wb_mem_data_q;
  assign wbAluOutput      = wb_alu_q;
  assign wbMemOutOrAluOut = wb_m2r_q;
  assign wbRegWrite       = wb_rw_q;
  assign wbWriteReg       = wb_wreg_q;
  assign misalignedFault  = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a behavioural model of the stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid;
  logic [31:0] exAluOutput;
  logic [31:0] exStoreData;
  logic        exMemRead;
  logic        exMemWrite;
  logic [1:0]  exMemSize;
  logic        exMemUnsigned;
  logic        exMemToReg;
  logic        exRegWrite;
  logic [4:0]  exWriteReg;
  logic        memStall;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemByteEn;
  logic [31:0] dmemRdata;
  logic        dmemAck;
  logic        wbValid;
  logic [31:0] wbMemoryData;
  logic [31:0] wbAluOutput;
  logic        wbMemOutOrAluOut;
  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic        misalignedFault;

  mem_access_stage dut (
    .clk              (clk),
    .rst              (rst),
    .exValid          (exValid),
    .exAluOutput      (exAluOutput),
    .exStoreData      (exStoreData),
    .exMemRead        (exMemRead),
    .exMemWrite       (exMemWrite),
    .exMemSize        (exMemSize),
    .exMemUnsigned    (exMemUnsigned),
    .exMemToReg       (exMemToReg),
    .exRegWrite       (exRegWrite),
    .exWriteReg       (exWriteReg),
    .memStall         (memStall),
    .dmemReq          (dmemReq),
    .dmemWe           (dmemWe),
    .dmemAddr         (dmemAddr),
    .dmemWdata        (dmemWdata),
    .dmemByteEn       (dmemByteEn),
    .dmemRdata        (dmemRdata),
    .dmemAck          (dmemAck),
    .wbValid          (wbValid),
    .wbMemoryData     (wbMemoryData),
    .wbAluOutput      (wbAluOutput),
    .wbMemOutOrAluOut (wbMemOutOrAluOut),
    .wbRegWrite       (wbRegWrite),
    .wbWriteReg       (wbWriteReg),
    .misalignedFault  (misalignedFault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected behaviour of the current cycle, set by the driver just after each edge.
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0;
  logic [31:0] exp_addr = '0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_wbv = 1'b0;
  logic        exp_fault = 1'b0;
  logic [31:0] exp_alu = '0;
  logic        exp_m2r = 1'b0;
  logic        exp_rw = 1'b0;
  logic [4:0]  exp_wreg = '0;
  logic [31:0] model_mem_data = '0;

  int unsigned stall_cnt = 0;
  int unsigned req_seen = 0;
  logic [31:0] obs_wdata = '0;
  logic [3:0]  obs_be = '0;
  logic        obs_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 32'd2) != 0;
    return (a % 32'd4) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'b0001 << (a % 32'd4);
    if (sz == 2'd1) return 4'b0011 << (a % 32'd4);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
    int unsigned bits;
    int unsigned shamt;
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 2'd0) begin
      bits  = 8;
      shamt = 8 * (a % 32'd4);
    end else if (sz == 2'd1) begin
      bits  = 16;
      shamt = 16 * ((a / 32'd2) % 32'd2);
    end else begin
      return rd;
    end
    mask = (32'd1 << bits) - 32'd1;
    v = (rd >> shamt) & mask;
    if (!u && ((v >> (bits - 1)) & 32'd1) != 0) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("memStall", 32'(memStall), 32'(exp_stall));
      chk("dmemReq", 32'(dmemReq), 32'(exp_stall));
      if (exp_stall) begin
        chk("dmemAddr", dmemAddr, exp_addr);
        chk("dmemWe", 32'(dmemWe), 32'(exp_we));
        chk("dmemWdata", dmemWdata, exp_wdata);
        chk("dmemByteEn", 32'(dmemByteEn), 32'(exp_be));
        stall_cnt++;
        obs_wdata = dmemWdata;
        obs_be    = dmemByteEn;
        obs_we    = dmemWe;
      end
      if (dmemReq) req_seen++;
      chk("wbValid", 32'(wbValid), 32'(exp_wbv));
      chk("misalignedFault", 32'(misalignedFault), 32'(exp_fault));
      chk("wbRegWrite", 32'(wbRegWrite), 32'(exp_wbv & exp_rw));
      if (exp_wbv) begin
        chk("wbAluOutput", wbAluOutput, exp_alu);
        chk("wbMemOutOrAluOut", 32'(wbMemOutOrAluOut), 32'(exp_m2r));
        chk("wbWriteReg", 32'(wbWriteReg), 32'(exp_wreg));
      end
      chk("wbMemoryData", wbMemoryData, model_mem_data);
    end
  end

  // Presents one instruction while the stage is idle and plays the memory side.
  task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] sd,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                       input logic m2r, input logic rw, input logic [4:0] wreg,
                       input int unsigned k, input logic [31:0] rdata);
    logic is_mem;
    logic mis;
    exValid       = v;
    exAluOutput   = a;
    exStoreData   = sd;
    exMemRead     = rd;
    exMemWrite    = wr;
    exMemSize     = sz;
    exMemUnsigned = u;
    exMemToReg    = m2r;
    exRegWrite    = rw;
    exWriteReg    = wreg;
    dmemAck       = 1'($urandom_range(0, 1));
    dmemRdata     = $urandom;
    is_mem = rd | wr;
    mis    = is_mem && model_misaligned(sz, a);
    @(posedge clk); #1;
    dmemAck   = 1'b0;
    exp_wbv   = 1'b0;
    exp_fault = 1'b0;
    exp_stall = 1'b0;
    if (!v) begin
      exValid = 1'b0;
    end else if (!is_mem) begin
      exp_wbv  = 1'b1;
      exp_alu  = a;
      exp_m2r  = m2r;
      exp_rw   = rw;
      exp_wreg = wreg;
    end else if (mis) begin
      exp_fault = 1'b1;
    end else begin
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_we    = wr;
      exp_wdata = wr ? model_wdata(sz, sd) : 32'd0;
      exp_be    = wr ? model_be(sz, a) : 4'd0;
      for (int unsigned i = 1; i <= k; i++) begin
        exp_stall = 1'b1;
        dmemAck   = (i == k);
        dmemRdata = (i == k) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      dmemAck   = 1'b0;
      exp_stall = 1'b0;
      exp_wbv   = 1'b1;
      exp_alu   = a;
      exp_m2r   = m2r;
      exp_rw    = rw & ~wr;
      exp_wreg  = wreg;
      if (!wr) model_mem_data = model_load(rdata, a, sz, u);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    exValid = 1'b0; exAluOutput = '0; exStoreData = '0; exMemRead = 1'b0;
    exMemWrite = 1'b0; exMemSize = '0; exMemUnsigned = 1'b0; exMemToReg = 1'b0;
    exRegWrite = 1'b0; exWriteReg = '0; dmemRdata = '0; dmemAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memStall", 32'(memStall), 32'd0);
    chk("rst_dmemReq", 32'(dmemReq), 32'd0);
    chk("rst_dmemWe", 32'(dmemWe), 32'd0);
    chk("rst_dmemAddr", dmemAddr, 32'd0);
    chk("rst_dmemWdata", dmemWdata, 32'd0);
    chk("rst_dmemByteEn", 32'(dmemByteEn), 32'd0);
    chk("rst_wbValid", 32'(wbValid), 32'd0);
    chk("rst_wbMemoryData", wbMemoryData, 32'd0);
    chk("rst_wbAluOutput", wbAluOutput, 32'd0);
    chk("rst_wbRegWrite", 32'(wbRegWrite), 32'd0);
    chk("rst_misalignedFault", 32'(misalignedFault), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Three back-to-back ALU ops.
    stall_cnt = 0;
    issue(1'b1, 32'h0000_0111, '0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd5, 0, '0);
    chk("alu1_out", wbAluOutput, 32'h0000_0111);
    issue(1'b1, 32'h0000_0222, '0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd6, 0, '0);
    chk("alu2_reg", 32'(wbWriteReg), 32'd6);
    issue(1'b1, 32'h0000_0333, '0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd7, 0, '0);
    chk("alu3_out", wbAluOutput, 32'h0000_0333);
    chk("alu3_valid", 32'(wbValid), 32'd1);
    chk("alu_stalls", stall_cnt, 32'd0);

    // lb / lbu at 0x1003, ack after three busy cycles.
    stall_cnt = 0;
    issue(1'b1, 32'h0000_1003, '0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd8, 3, 32'h80FF_1234);
    chk("lb_data", wbMemoryData, 32'hFFFF_FF80);
    chk("lb_stalls", stall_cnt, 32'd3);
    chk("lb_be", 32'(obs_be), 32'd0);
    chk("lb_regwrite", 32'(wbRegWrite), 32'd1);
    issue(1'b1, 32'h0000_1003, '0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 5'd9, 2, 32'h80FF_1234);
    chk("lbu_data", wbMemoryData, 32'h0000_0080);

    // sh at 0x2002.
    issue(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 5'd10, 1, '0);
    chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_we", 32'(obs_we), 32'd1);
    chk("sh_valid", 32'(wbValid), 32'd1);
    chk("sh_regwrite", 32'(wbRegWrite), 32'd0);

    // Misaligned lw then an add.
    req_seen = 0;
    issue(1'b1, 32'h0000_3002, '0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 5'd11, 2, 32'h1111_2222);
    chk("mis_fault", 32'(misalignedFault), 32'd1);
    chk("mis_valid", 32'(wbValid), 32'd0);
    issue(1'b1, 32'h0000_0444, '0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd12, 0, '0);
    chk("mis_next_valid", 32'(wbValid), 32'd1);
    chk("mis_next_fault", 32'(misalignedFault), 32'd0);
    chk("mis_no_req", req_seen, 32'd0);

    // lh / lhu at 0x4000.
    issue(1'b1, 32'h0000_4000, '0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 5'd13, 2, 32'h1234_8001);
    chk("lh_data", wbMemoryData, 32'hFFFF_8001);
    issue(1'b1, 32'h0000_4000, '0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd14, 1, 32'h1234_8001);
    chk("lhu_data", wbMemoryData, 32'h0000_8001);

    // Reset while busy; the ack arrives afterwards and must be ignored.
    exValid = 1'b1; exAluOutput = 32'h0000_5000; exMemRead = 1'b1; exMemWrite = 1'b0;
    exMemSize = 2'd2; exMemUnsigned = 1'b0; exMemToReg = 1'b1; exRegWrite = 1'b1;
    exWriteReg = 5'd15; dmemAck = 1'b0;
    @(posedge clk); #1;
    exp_wbv = 1'b0; exp_fault = 1'b0;
    exp_stall = 1'b1; exp_addr = 32'h0000_5000; exp_we = 1'b0; exp_wdata = '0; exp_be = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exValid = 1'b0;
    exp_stall = 1'b0; model_mem_data = '0;
    chk("rstb_dmemReq", 32'(dmemReq), 32'd0);
    chk("rstb_memStall", 32'(memStall), 32'd0);
    chk("rstb_dmemAddr", dmemAddr, 32'd0);
    chk("rstb_wbMemoryData", wbMemoryData, 32'd0);
    @(posedge clk); #1;
    dmemAck = 1'b1; dmemRdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmemAck = 1'b0;
    chk("stray_ack_valid", 32'(wbValid), 32'd0);
    chk("stray_ack_req", 32'(dmemReq), 32'd0);

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      issue(r != 9, a, $urandom, (r >= 4 && r < 7), (r >= 7 && r < 9),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom_range(1, 4), $urandom);
    end
    issue(1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 0, '0);
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
